// File: rtl/player_move_ctrl.sv
// Player movement/attack controller: turns key pulses into tile positions and attack pulses,
// honouring map bounds, walkable tiles, player-vs-player occupancy and per-player cooldowns.

module pmc_player #(
  parameter int unsigned HMAXTILE = 9,
  parameter int unsigned VMAXTILE = 5,
  parameter int unsigned MOVE_CD  = 10_000_000,
  parameter int unsigned ATK_CD   = 100_000_000,
  parameter int unsigned START_H  = 0,
  parameter int unsigned START_V  = 0,
  parameter int unsigned W        = (HMAXTILE+1)*(VMAXTILE+1)+1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   key,
  input  logic [W-1:0] walk_able,
  input  logic         accept,
  output logic         want,
  output logic [3:0]   tgt_h,
  output logic [3:0]   tgt_v,
  output logic [3:0]   pos_h,
  output logic [3:0]   pos_v,
  output logic         busy,
  output logic         atk_pulse
);
  localparam int MCW = $clog2(MOVE_CD + 1);
  localparam int ACW = $clog2(ATK_CD + 1);
  localparam int IW  = $clog2(W);

  typedef enum logic {IDLE, COOLDOWN} state_t;

  state_t          state_q, state_d;
  logic [MCW-1:0]  mcnt_q, mcnt_d;
  logic [ACW-1:0]  acnt_q, acnt_d;
  logic [3:0]      pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  logic            atk_q, atk_d;
  logic [4:0]      th5, tv5;
  logic            dir_vld, in_bounds;
  logic [IW-1:0]   idx;

  // 5-bit target so a step off the low edge shows up as a large value, not a wrap
  always_comb begin
    th5     = {1'b0, pos_h_q};
    tv5     = {1'b0, pos_v_q};
    dir_vld = 1'b1;
    if (key[0])      tv5 = tv5 - 5'd1;
    else if (key[1]) tv5 = tv5 + 5'd1;
    else if (key[2]) th5 = th5 - 5'd1;
    else if (key[3]) th5 = th5 + 5'd1;
    else             dir_vld = 1'b0;
    in_bounds = (th5 <= 5'(HMAXTILE)) && (tv5 <= 5'(VMAXTILE));
    idx       = in_bounds ? (IW'(tv5) * IW'(HMAXTILE + 1) + IW'(th5)) : '0;
    want      = (state_q == IDLE) && dir_vld && in_bounds && walk_able[idx];
    tgt_h     = th5[3:0];
    tgt_v     = tv5[3:0];
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = COOLDOWN;
        mcnt_d  = MCW'(MOVE_CD - 1);
        pos_h_d = tgt_h;
        pos_v_d = tgt_v;
      end
      COOLDOWN: begin
        if (mcnt_q == '0) state_d = IDLE;
        else              mcnt_d  = mcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // attack path runs alongside the move FSM
  always_comb begin
    atk_d  = 1'b0;
    acnt_d = acnt_q;
    if (acnt_q == '0) begin
      if (key[4]) begin
        atk_d  = 1'b1;
        acnt_d = ACW'(ATK_CD - 1);
      end
    end else begin
      acnt_d = acnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcnt_q  <= '0;
      acnt_q  <= '0;
      atk_q   <= 1'b0;
      pos_h_q <= 4'(START_H);
      pos_v_q <= 4'(START_V);
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      acnt_q  <= acnt_d;
      atk_q   <= atk_d;
      pos_h_q <= pos_h_d;
      pos_v_q <= pos_v_d;
    end
  end

  assign pos_h     = pos_h_q;
  assign pos_v     = pos_v_q;
  assign busy      = (state_q == COOLDOWN);
  assign atk_pulse = atk_q;
endmodule

module player_move_ctrl #(
  parameter int unsigned HMAXTILE  = 9,
  parameter int unsigned VMAXTILE  = 5,
  parameter int unsigned MOVE_CD   = 25'd10_000_000,
  parameter int unsigned ATK_CD    = 27'd100_000_000,
  parameter int unsigned A_START_H = 0,
  parameter int unsigned A_START_V = 0,
  parameter int unsigned B_START_H = 9,
  parameter int unsigned B_START_V = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [4:0]                              keyA,
  input  logic [4:0]                              keyB,
  input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]      walkAble,
  output logic [3:0]                              curAh,
  output logic [3:0]                              curAv,
  output logic [3:0]                              curBh,
  output logic [3:0]                              curBv,
  output logic                                    atkFromA,
  output logic                                    atkFromB,
  output logic                                    busyA,
  output logic                                    busyB
);
  localparam int unsigned W = (HMAXTILE+1)*(VMAXTILE+1)+1;

  logic [1:0][4:0] key_v;
  logic [1:0]      want, busy_v, atk_v;
  logic [1:0][3:0] tgt_h, tgt_v, pos_h, pos_v;
  logic            acc_a, acc_b;

  assign key_v = {keyB, keyA};

  for (genvar g = 0; g < 2; g++) begin : g_player
    pmc_player #(
      .HMAXTILE(HMAXTILE), .VMAXTILE(VMAXTILE),
      .MOVE_CD(MOVE_CD), .ATK_CD(ATK_CD),
      .START_H((g == 0) ? A_START_H : B_START_H),
      .START_V((g == 0) ? A_START_V : B_START_V),
      .W(W)
    ) u_player (
      .clk(clk), .rst(rst), .key(key_v[g]), .walk_able(walkAble),
      .accept((g == 0) ? acc_a : acc_b),
      .want(want[g]), .tgt_h(tgt_h[g]), .tgt_v(tgt_v[g]),
      .pos_h(pos_h[g]), .pos_v(pos_v[g]),
      .busy(busy_v[g]), .atk_pulse(atk_v[g])
    );
  end

  // Occupancy uses current positions; A wins a same-target tie
  always_comb begin
    acc_a = want[0] && !((tgt_h[0] == pos_h[1]) && (tgt_v[0] == pos_v[1]));
    acc_b = want[1] && !((tgt_h[1] == pos_h[0]) && (tgt_v[1] == pos_v[0]))
                    && !(acc_a && (tgt_h[1] == tgt_h[0]) && (tgt_v[1] == tgt_v[0]));
  end

  assign curAh    = pos_h[0];
  assign curAv    = pos_v[0];
  assign curBh    = pos_h[1];
  assign curBv    = pos_v[1];
  assign busyA    = busy_v[0];
  assign busyB    = busy_v[1];
  assign atkFromA = atk_v[0];
  assign atkFromB = atk_v[1];
endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: cycle-level model in absolute cycle numbers plus directed literal checks.

module tb_player_move_ctrl;
  localparam int M  = 6;
  localparam int AC = 8;
  localparam logic [4:0] KU = 5'b00001, KD = 5'b00010, KL = 5'b00100,
                         KR = 5'b01000, KT = 5'b10000, K0 = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  keyA, keyB;
  logic [60:0] walk;
  logic [3:0]  curAh, curAv, curBh, curBv;
  logic        atkFromA, atkFromB, busyA, busyB;

  always #5 clk = ~clk;

  player_move_ctrl #(.MOVE_CD(M), .ATK_CD(AC)) dut (
    .clk(clk), .rst(rst), .keyA(keyA), .keyB(keyB), .walkAble(walk),
    .curAh(curAh), .curAv(curAv), .curBh(curBh), .curBv(curBv),
    .atkFromA(atkFromA), .atkFromB(atkFromB), .busyA(busyA), .busyB(busyB)
  );

  // model: positions plus the first cycle at which each action is allowed again
  int ah, av, bh, bv;
  int a_ok, b_ok, aa_ok, ba_ok;
  int m_atk_a, m_atk_b;
  int cyc = 0;
  bit chk_en = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int h, input int v);
    if (h < 0 || h > 9 || v < 0 || v > 5) return 1'b0;
    return walk[v*10 + h];
  endfunction

  task automatic target(input logic [4:0] k, input int h, input int v,
                        output int th, output int tv, output bit d);
    th = h; tv = v; d = 1'b1;
    if (k[0])      tv = v - 1;
    else if (k[1]) tv = v + 1;
    else if (k[2]) th = h - 1;
    else if (k[3]) th = h + 1;
    else           d = 1'b0;
  endtask

  task automatic model_step();
    int tah, tav, tbh, tbv;
    bit da, db, acc_a, acc_b;
    if (rst) begin
      ah = 0; av = 0; bh = 9; bv = 5;
      a_ok = 0; b_ok = 0; aa_ok = 0; ba_ok = 0;
      m_atk_a = 0; m_atk_b = 0;
    end else begin
      m_atk_a = (keyA[4] && cyc >= aa_ok) ? 1 : 0;
      m_atk_b = (keyB[4] && cyc >= ba_ok) ? 1 : 0;
      if (m_atk_a != 0) aa_ok = cyc + AC;
      if (m_atk_b != 0) ba_ok = cyc + AC;
      target(keyA, ah, av, tah, tav, da);
      target(keyB, bh, bv, tbh, tbv, db);
      acc_a = da && cyc >= a_ok && legal(tah, tav) && !(tah == bh && tav == bv);
      acc_b = db && cyc >= b_ok && legal(tbh, tbv) && !(tbh == ah && tbv == av)
                 && !(acc_a && tah == tbh && tav == tbv);
      if (acc_a) begin ah = tah; av = tav; a_ok = cyc + M + 1; end
      if (acc_b) begin bh = tbh; bv = tbv; b_ok = cyc + M + 1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    keyA = K0;
    keyB = K0;
  endtask

  task automatic press(input logic [4:0] a, input logic [4:0] b);
    keyA = a;
    keyB = b;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("curAh", curAh, ah);
      check("curAv", curAv, av);
      check("curBh", curBh, bh);
      check("curBv", curBv, bv);
      check("atkFromA", atkFromA, m_atk_a);
      check("atkFromB", atkFromB, m_atk_b);
      check("busyA", busyA, int'(cyc < a_ok));
      check("busyB", busyB, int'(cyc < b_ok));
    end
  end

  logic [4:0] pa [7];
  logic [4:0] pb [7];

  initial begin
    rst = 1'b1; keyA = K0; keyB = K0; walk = '1;
    pa = '{KD, KR, KR, KR, K0, K0, K0};
    pb = '{KU, KU, KU, KL, KL, KL, KL};
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_curAh", curAh, 0);
    check("rst_curAv", curAv, 0);
    check("rst_curBh", curBh, 9);
    check("rst_curBv", curBv, 5);
    check("rst_busyA", busyA, 0);
    check("rst_atkA", atkFromA, 0);

    // first move and cooldown length; a pulse during cooldown is dropped
    press(KR, K0);
    check("mv_curAh", curAh, 1);
    check("mv_curAv", curAv, 0);
    check("mv_busyA", busyA, 1);
    press(KR, K0);
    idle(M - 3);
    tick();
    check("cd_busy_m1", busyA, 1);
    tick();
    check("cd_busy_end", busyA, 0);
    check("cd_dropped", curAh, 1);

    // edges of the map
    rst = 1'b1; tick(); rst = 1'b0;
    press(KU, K0);
    check("up_edge_v", curAv, 0);
    check("up_edge_busy", busyA, 0);
    press(KL, K0);
    check("left_edge_h", curAh, 0);
    check("left_edge_busy", busyA, 0);

    // priority: down beats right
    press(KD | KR, K0);
    check("prio_h", curAh, 0);
    check("prio_v", curAv, 1);
    idle(M);

    // unwalkable tile
    walk[11] = 1'b0;
    press(KR, K0);
    check("blk_curAh", curAh, 0);
    check("blk_busyA", busyA, 0);
    walk[11] = 1'b1;

    // bring A to (3,2) and B to (5,2)
    for (int i = 0; i < 7; i++) begin
      press(pa[i], pb[i]);
      idle(M);
    end
    check("setup_Ah", curAh, 3);
    check("setup_Bh", curBh, 5);
    check("setup_Bv", curBv, 2);

    // same target: A wins
    press(KR, KL);
    check("tie_Ah", curAh, 4);
    check("tie_Av", curAv, 2);
    check("tie_Bh", curBh, 5);
    idle(M);
    // swap: both blocked
    press(KR, KL);
    check("swap_Ah", curAh, 4);
    check("swap_Bh", curBh, 5);
    check("swap_busyB", busyB, 0);
    // B into the tile A is vacating: blocked
    press(KU, KL);
    check("vac_Av", curAv, 1);
    check("vac_Bh", curBh, 5);
    check("vac_busyB", busyB, 0);
    idle(M);

    // attack cooldown
    press(KT, K0);
    check("atk_t1", atkFromA, 1);
    tick();
    check("atk_t2", atkFromA, 0);
    idle(3);
    press(KT, K0);
    check("atk_ignored", atkFromA, 0);
    idle(3);
    press(KT, K0);
    check("atk_again", atkFromA, 1);

    // attack plus move together
    press(K0, KT | KL);
    check("atkmv_atkB", atkFromB, 1);
    check("atkmv_Bh", curBh, 4);
    idle(M);

    // reset aborts a cooldown
    rst = 1'b1; tick(); rst = 1'b0;
    press(K0, KL);
    check("rb_Bh", curBh, 8);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rb_rst_Bh", curBh, 9);
    check("rb_rst_Bv", curBv, 5);
    check("rb_rst_busyB", busyB, 0);
    press(K0, KL);
    check("rb_after_Bh", curBh, 8);
    check("rb_after_busyB", busyB, 1);

    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
